// File: rtl/ahfp_pkg.sv
// Shared types and constants for the AHFP adder subsystem.
package ahfp_pkg;

  localparam int FP_W     = 32;
  localparam int DEF_NREQ = 4;
  localparam int DEF_IDW  = (DEF_NREQ > 1) ? $clog2(DEF_NREQ) : 1;

  // IEEE-754 single precision layout.
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  typedef logic [DEF_IDW-1:0] req_id_t;

  // Requester ID width; never narrower than one bit.
  function automatic int id_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ahfp_add_sched_if.sv
// Requester, shared-adder and result buses of the add scheduler.
// Handshake: each requester holds req[i] and its operands stable until it
// sees grant[i]=1; the pair is captured at the end of that cycle. A result
// transfers on any edge where result_valid and result_ready are both high;
// while result_valid is high and result_ready low the result is held.
interface ahfp_add_sched_if import ahfp_pkg::*; #(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = id_width(NREQ)
) ();

  logic [NREQ-1:0]      req;
  logic [FP_W*NREQ-1:0] dataa_in;
  logic [FP_W*NREQ-1:0] datab_in;
  logic [NREQ-1:0]      grant;
  logic [FP_W-1:0]      add_dataa;
  logic [FP_W-1:0]      add_datab;
  logic [FP_W-1:0]      add_result;
  logic [FP_W-1:0]      result;
  logic [IDW-1:0]       result_id;
  logic                 result_valid;
  logic                 result_ready;

  // Scheduler side.
  modport master (
    input  req, dataa_in, datab_in, add_result, result_ready,
    output grant, add_dataa, add_datab, result, result_id, result_valid
  );

  // Requesters, adder and result consumer side.
  modport slave (
    output req, dataa_in, datab_in, add_result, result_ready,
    input  grant, add_dataa, add_datab, result, result_id, result_valid
  );

endinterface

// File: rtl/ahfp_rr_arb.sv
// Combinational round-robin arbiter: searches upward from ptr+1, wrapping,
// and returns a one-hot grant plus the winner index.
module ahfp_rr_arb import ahfp_pkg::*; #(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            enable_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  win_o
);

  logic [IDW-1:0] cand;
  logic           found;

  // Walk NREQ candidates starting just after the last winner.
  always_comb begin
    grant_o = '0;
    win_o   = '0;
    found   = 1'b0;
    cand    = ptr_i;
    for (int k = 0; k < NREQ; k++) begin
      if (cand == IDW'(NREQ - 1)) cand = '0;
      else                        cand = cand + IDW'(1);
      if (enable_i && !found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        win_o         = cand;
      end
    end
  end

endmodule

// File: rtl/ahfp_add_sched.sv
// Round-robin scheduler sharing one combinational ahfp_add among NREQ
// requesters: operand stage feeds the adder, result stage holds the sum
// tagged with its requester ID under valid/ready backpressure.
module ahfp_add_sched import ahfp_pkg::*; #(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  ahfp_add_sched_if.master   bus,
  output logic [IDW-1:0]     dbg_ptr_o,
  output logic               dbg_op_valid_o
);

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic            op_valid_q, op_valid_d;
  logic [IDW-1:0]  op_id_q, op_id_d;
  fp32_t           op_a_q, op_a_d;
  fp32_t           op_b_q, op_b_d;
  logic [FP_W-1:0] res_q, res_d;
  logic [IDW-1:0]  res_id_q, res_id_d;
  logic            res_valid_q, res_valid_d;

  logic            stall;
  logic            arb_en;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  win;
  fp32_t           win_a, win_b;

  // A held result freezes the whole pipe; no grant while stalled or in reset.
  assign stall  = res_valid_q && !bus.result_ready;
  assign arb_en = reset_n && !stall;

  ahfp_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_i    (bus.req),
    .ptr_i    (ptr_q),
    .enable_i (arb_en),
    .grant_o  (grant),
    .win_o    (win)
  );

  // Select the winner's operand pair with the one-hot grant.
  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        win_a = bus.dataa_in[FP_W*i +: FP_W];
        win_b = bus.datab_in[FP_W*i +: FP_W];
      end
    end
  end

  // Next state: both stages advance together unless stalled.
  always_comb begin
    ptr_d       = ptr_q;
    op_valid_d  = op_valid_q;
    op_id_d     = op_id_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    res_d       = res_q;
    res_id_d    = res_id_q;
    res_valid_d = res_valid_q;
    if (!stall) begin
      op_valid_d = |grant;
      if (|grant) begin
        op_a_d  = win_a;
        op_b_d  = win_b;
        op_id_d = win;
        ptr_d   = win;
      end
      res_valid_d = op_valid_q;
      if (op_valid_q) begin
        res_d    = bus.add_result;
        res_id_d = op_id_q;
      end
    end
  end

  // State registers; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q       <= IDW'(NREQ - 1);
      op_valid_q  <= 1'b0;
      op_id_q     <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      res_q       <= '0;
      res_id_q    <= '0;
      res_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      op_valid_q  <= op_valid_d;
      op_id_q     <= op_id_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      res_q       <= res_d;
      res_id_q    <= res_id_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign bus.grant        = grant;
  assign bus.add_dataa    = op_a_q;
  assign bus.add_datab    = op_b_q;
  assign bus.result       = res_q;
  assign bus.result_id    = res_id_q;
  assign bus.result_valid = res_valid_q;
  assign dbg_ptr_o        = ptr_q;
  assign dbg_op_valid_o   = op_valid_q;

endmodule

// File: tb/tb_ahfp_add_sched.sv
// Bench for ahfp_add_sched: a stand-in adder, a cycle monitor comparing the
// DUT against a queue-based round-robin reference, directed vector table,
// hand-written corner sequences and a randomized phase.
module tb_ahfp_add_sched;
  import ahfp_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_n;
  logic [IDW-1:0] dbg_ptr;
  logic dbg_op_valid;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  ahfp_add_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  ahfp_add_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (bus),
    .dbg_ptr_o      (dbg_ptr),
    .dbg_op_valid_o (dbg_op_valid)
  );

  // Stand-in for ahfp_add: exact FP sums for the listed pairs, integer sum
  // otherwise. The scheduler only passes values through, so any function works.
  function automatic logic [31:0] fake_add(logic [31:0] a, logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
    if (a == 32'h40000000 && b == 32'h3F800000) return 32'h40400000;
    if (a == 32'h40400000 && b == 32'h3F800000) return 32'h40800000;
    if (a == 32'hBF800000 && b == 32'h3F800000) return 32'h00000000;
    if (a == 32'h40000000 && b == 32'h40000000) return 32'h40800000;
    return a + b;
  endfunction

  assign bus.add_result = fake_add(bus.add_dataa, bus.add_datab);

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: next winner is the first requester after the last winner.
  function automatic int rr_pick(logic [NREQ-1:0] r, int last);
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (last + k) % NREQ;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  typedef struct {
    int          id;
    logic [31:0] val;
    int          avail;
  } inflight_t;

  inflight_t   mq[$];          // granted ops in grant order
  logic [31:0] exp_q[$];       // scratch expected-value queue for directed checks
  int          m_last = NREQ - 1;
  int          cyc = 0;

  int          g_log[$];
  int          g_cyc[$];
  int          r_id[$];
  logic [31:0] r_val[$];
  int          r_cyc[$];

  task automatic clear_logs();
    g_log.delete(); g_cyc.delete();
    r_id.delete(); r_val.delete(); r_cyc.delete();
  endtask

  // Monitor: compare every cycle on the falling edge, advance model on rising.
  initial begin : monitor
    logic            m_rv, s_rst, s_rdy;
    logic [NREQ-1:0] s_req, exp_g;
    logic [31:0]     wa, wb;
    int              win;
    @(posedge clk);
    forever begin
      @(negedge clk);
      s_rst = reset_n;
      s_req = bus.req;
      s_rdy = bus.result_ready;
      m_rv  = (mq.size() > 0) && (mq[0].avail <= cyc);
      win   = (!s_rst || (m_rv && !s_rdy)) ? -1 : rr_pick(s_req, m_last);
      exp_g = (win >= 0) ? (NREQ'(1) << win) : '0;
      wa = '0;
      wb = '0;
      if (win >= 0) begin
        wa = bus.dataa_in[32*win +: 32];
        wb = bus.datab_in[32*win +: 32];
      end
      chk("mon_grant", 32'(bus.grant), 32'(exp_g));
      chk("mon_result_valid", 32'(bus.result_valid), 32'(m_rv));
      if (m_rv) begin
        chk("mon_result", bus.result, mq[0].val);
        chk("mon_result_id", 32'(bus.result_id), 32'(mq[0].id));
      end
      if (s_rst && (|bus.grant)) begin
        for (int i = 0; i < NREQ; i++) if (bus.grant[i]) begin
          g_log.push_back(i);
          g_cyc.push_back(cyc);
        end
      end
      if (s_rst && bus.result_valid && s_rdy) begin
        r_id.push_back(int'(bus.result_id));
        r_val.push_back(bus.result);
        r_cyc.push_back(cyc);
      end
      @(posedge clk);
      if (!s_rst) begin
        mq.delete();
        m_last = NREQ - 1;
      end else begin
        if (m_rv && s_rdy) void'(mq.pop_front());
        if (win >= 0) begin
          mq.push_back('{win, fake_add(wa, wb), cyc + 2});
          m_last = win;
        end
      end
      cyc++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int id, input logic [31:0] a, input logic [31:0] b);
    bus.dataa_in[32*id +: 32] = a;
    bus.datab_in[32*id +: 32] = b;
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    repeat (n) step();
    reset_n = 1'b1;
    clear_logs();
  endtask

  // Run n cycles; unless hold, each requester drops req right after its grant.
  task automatic run_cycles(input int n, input bit hold);
    logic [NREQ-1:0] g;
    repeat (n) begin
      @(negedge clk);
      g = bus.grant;
      @(posedge clk);
      #1;
      if (!hold) bus.req = bus.req & ~g;
    end
  endtask

  task automatic chk_ids(input string name, input int act[$], input int exp[$]);
    chk({name, "_count"}, 32'(act.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < act.size(); i++)
      chk(name, 32'(act[i]), 32'(exp[i]));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : main
    int cnt;
    logic [NREQ-1:0] g;

    vecs[0] = '{0, 32'h3F800000, 32'h3F800000, 32'h40000000};
    vecs[1] = '{1, 32'h40000000, 32'h3F800000, 32'h40400000};
    vecs[2] = '{2, 32'h40400000, 32'h3F800000, 32'h40800000};
    vecs[3] = '{3, 32'hBF800000, 32'h3F800000, 32'h00000000};
    vecs[4] = '{3, 32'h40000000, 32'h40000000, 32'h40800000};
    vecs[5] = '{0, 32'h00001234, 32'h00000010, 32'h00001244};

    reset_n          = 1'b0;
    bus.req          = '1;
    bus.dataa_in     = '0;
    bus.datab_in     = '0;
    bus.result_ready = 1'b1;

    // Reset state, with requests pending to show grant is forced low.
    step();
    @(negedge clk);
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_result_valid", 32'(bus.result_valid), 32'h0);
    chk("rst_result", bus.result, 32'h0);
    chk("rst_result_id", 32'(bus.result_id), 32'h0);
    chk("rst_add_dataa", bus.add_dataa, 32'h0);
    chk("rst_add_datab", bus.add_datab, 32'h0);
    chk("rst_ptr", 32'(dbg_ptr), 32'(NREQ - 1));
    chk("rst_op_valid", 32'(dbg_op_valid), 32'h0);
    bus.req = '0;
    step();
    reset_n = 1'b1;
    clear_logs();

    // Table: single requester, grant in T, result only in T+2.
    foreach (vecs[v]) begin
      set_ops(vecs[v].id, vecs[v].a, vecs[v].b);
      bus.req = NREQ'(1) << vecs[v].id;
      cnt = 0;
      @(negedge clk);
      while (!bus.grant[vecs[v].id] && cnt < 10) begin
        @(negedge clk);
        cnt++;
      end
      n_checks++;
      if (cnt >= 10) begin
        n_fail++;
        $display("FAIL vec_grant_wait: no grant to %0d within 10 cycles", vecs[v].id);
      end
      chk("vec_grant_T", 32'(cnt), 32'h0);
      step();
      bus.req = '0;
      @(negedge clk);
      chk("vec_valid_T1", 32'(bus.result_valid), 32'h0);
      step();
      @(negedge clk);
      chk("vec_valid_T2", 32'(bus.result_valid), 32'h1);
      chk("vec_result", bus.result, vecs[v].exp);
      chk("vec_result_id", 32'(bus.result_id), 32'(vecs[v].id));
      step();
      @(negedge clk);
      chk("vec_valid_once", 32'(bus.result_valid), 32'h0);
      step();
    end

    // Two requesters: grant order 1,2; results back-to-back.
    do_reset(1);
    set_ops(1, 32'h40000000, 32'h3F800000);
    set_ops(2, 32'h40000000, 32'h3F800000);
    bus.req = 4'b0110;
    run_cycles(6, 1'b0);
    chk_ids("two_grant_order", g_log, '{1, 2});
    chk_ids("two_result_ids", r_id, '{1, 2});
    exp_q = '{32'h40400000, 32'h40400000};
    foreach (exp_q[i]) if (i < r_val.size()) chk("two_result_val", r_val[i], exp_q[i]);
    if (r_cyc.size() == 2) chk("two_back_to_back", 32'(r_cyc[1] - r_cyc[0]), 32'h1);

    // All four held: rotating grants, no bubbles, results two cycles later.
    do_reset(1);
    for (int i = 0; i < NREQ; i++) set_ops(i, 32'h100 * i + 1, 32'h5);
    bus.req = 4'b1111;
    run_cycles(8, 1'b1);
    bus.req = '0;
    run_cycles(4, 1'b0);
    chk_ids("all_grant_order", g_log, '{0, 1, 2, 3, 0, 1, 2, 3});
    chk_ids("all_result_ids", r_id, '{0, 1, 2, 3, 0, 1, 2, 3});
    for (int i = 0; i < g_cyc.size() && i < r_cyc.size(); i++)
      chk("all_latency", 32'(r_cyc[i] - g_cyc[i]), 32'h2);

    // Backpressure: first result held three cycles, grants frozen meanwhile.
    do_reset(1);
    bus.result_ready = 1'b0;
    for (int i = 0; i < 3; i++) set_ops(i, 32'h200 + i, 32'h1);
    bus.req = 4'b0111;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      g = bus.grant;
      if (c >= 2 && c <= 4) begin
        chk("stall_grant", 32'(bus.grant), 32'h0);
        chk("stall_valid", 32'(bus.result_valid), 32'h1);
        chk("stall_hold_id", 32'(bus.result_id), 32'h0);
        chk("stall_hold_val", bus.result, 32'h201);
      end
      step();
      bus.req = bus.req & ~g;
      if (c == 4) bus.result_ready = 1'b1;
    end
    chk_ids("stall_grant_order", g_log, '{0, 1, 2});
    chk_ids("stall_result_ids", r_id, '{0, 1, 2});

    // Reset while both stages are occupied: in-flight work disappears.
    do_reset(1);
    set_ops(0, 32'h11, 32'h1);
    set_ops(1, 32'h22, 32'h1);
    bus.req = 4'b0011;
    run_cycles(2, 1'b0);
    reset_n = 1'b0;
    set_ops(1, 32'h33, 32'h1);
    set_ops(3, 32'h44, 32'h1);
    bus.req = 4'b1010;
    @(negedge clk);
    chk("midrst_op_valid_before", 32'(dbg_op_valid), 32'h1);
    chk("midrst_valid_before", 32'(bus.result_valid), 32'h1);
    chk("midrst_grant_in_reset", 32'(bus.grant), 32'h0);
    step();
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_valid_after", 32'(bus.result_valid), 32'h0);
    chk("midrst_op_valid_after", 32'(dbg_op_valid), 32'h0);
    chk("midrst_ptr", 32'(dbg_ptr), 32'(NREQ - 1));
    chk("midrst_first_grant", 32'(bus.grant), 32'b0010);
    g = bus.grant;
    step();
    bus.req = bus.req & ~g;
    run_cycles(6, 1'b0);
    chk_ids("midrst_grant_order", g_log, '{0, 1, 1, 3});
    chk_ids("midrst_result_ids", r_id, '{1, 3});
    exp_q = '{32'h34, 32'h45};
    foreach (exp_q[i]) if (i < r_val.size()) chk("midrst_result_val", r_val[i], exp_q[i]);

    // Requester 3 withdraws before being served; 0 is served twice.
    do_reset(1);
    set_ops(0, 32'h50, 32'h1);
    set_ops(3, 32'h70, 32'h1);
    bus.req = 4'b1001;
    @(negedge clk);
    chk("drop_first_grant", 32'(bus.grant), 32'b0001);
    step();
    set_ops(0, 32'h60, 32'h1);
    bus.req = 4'b0001;
    @(negedge clk);
    chk("drop_second_grant", 32'(bus.grant), 32'b0001);
    step();
    bus.req = '0;
    run_cycles(4, 1'b0);
    chk("drop_ptr", 32'(dbg_ptr), 32'h0);
    chk_ids("drop_grant_order", g_log, '{0, 0});
    chk_ids("drop_result_ids", r_id, '{0, 0});
    exp_q = '{32'h51, 32'h61};
    foreach (exp_q[i]) if (i < r_val.size()) chk("drop_result_val", r_val[i], exp_q[i]);

    // Randomized traffic and backpressure, checked by the monitor.
    do_reset(1);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      g = bus.grant;
      step();
      bus.result_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req[i]) begin
          if (g[i]) begin
            bus.req[i] = ($urandom_range(0, 1) == 1);
            set_ops(i, $urandom(), $urandom());
          end else if ($urandom_range(0, 15) == 0) begin
            bus.req[i] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          bus.req[i] = 1'b1;
          set_ops(i, $urandom(), $urandom());
        end
      end
    end
    bus.req = '0;
    bus.result_ready = 1'b1;
    run_cycles(6, 1'b0);
    chk("rand_drained", 32'(mq.size()), 32'h0);
    chk("rand_result_count", 32'(r_id.size()), 32'(g_log.size()));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
